// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated word FIFO and a valid/ready push port.
// Frames stream back-to-back from the FIFO; tx_o and busy_o are registered.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line high, waiting for the FIFO to hold a word
// S_START | start bit (low) for DIV cycles
// S_DATA  | DATA_W data bits, LSB first, DIV cycles each
// S_PAR   | parity bit for DIV cycles (only when PARITY != 0)
// S_STOP  | STOP_BITS stop bits (high); pops the next word on the final edge
module uart_tx_fifo #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_W      = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2 || DATA_W < 5 || DATA_W > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              push, pop, fifo_empty, par_bit;
  logic [DATA_W-1:0] head;

  state_t            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              bit_end;

  assign ready_o    = count_q < (AW+1)'(FIFO_DEPTH);
  assign push       = valid_i && ready_o;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign par_bit    = (PARITY == 1) ? ~^head : ^head;
  assign bit_end    = (baud_q == '0);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // FIFO occupancy next value: simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FSM state register plus bit timer, shifter and registered line output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; tx_d is the line level for the bit that starts next edge
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? baud_q : baud_q - 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          baud_d  = BW'(DIV - 1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = BW'(DIV - 1);
          if (bit_q == 4'(DATA_W - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
          baud_d  = BW'(DIV - 1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = BW'(DIV - 1);
          if (bit_q == 4'(STOP_BITS - 1)) begin
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Every pop starts a new frame immediately, from IDLE or the last stop edge
    if (pop) begin
      state_d = S_START;
      tx_d    = 1'b0;
      baud_d  = BW'(DIV - 1);
      shift_d = head;
      par_d   = par_bit;
    end
  end

  // Outputs; busy looks ahead at next state and count so it is registered
  always_comb begin
    busy_d       = (state_d != S_IDLE) || (count_d != '0);
    tx_o         = tx_q;
    busy_o       = busy_q;
    fifo_count_o = count_q;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV = 10 across four parameter sets.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [3];
  logic [6:0] din3;
  logic       vin  [4];
  logic       txo  [4];
  logic       bsy  [4];
  logic       rdy  [4];
  logic [2:0] cnt  [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // dut0: 8N1, dut1: 8E1, dut2: 8O1, dut3: 7N2; all with a 4-deep FIFO
  uart_tx_fifo #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .data_i(din[0]), .valid_i(vin[0]), .ready_o(rdy[0]),
    .tx_o(txo[0]), .busy_o(bsy[0]), .fifo_count_o(cnt[0]));
  uart_tx_fifo #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .data_i(din[1]), .valid_i(vin[1]), .ready_o(rdy[1]),
    .tx_o(txo[1]), .busy_o(bsy[1]), .fifo_count_o(cnt[1]));
  uart_tx_fifo #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .data_i(din[2]), .valid_i(vin[2]), .ready_o(rdy[2]),
    .tx_o(txo[2]), .busy_o(bsy[2]), .fifo_count_o(cnt[2]));
  uart_tx_fifo #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_W(7), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst), .data_i(din3), .valid_i(vin[3]), .ready_o(rdy[3]),
    .tx_o(txo[3]), .busy_o(bsy[3]), .fifo_count_o(cnt[3]));

  typedef struct {
    int          dut;
    logic [7:0]  word;
    logic [15:0] bits;   // expected line levels per bit period, LSB = start bit
    int          nbits;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input logic [7:0] w, input logic v);
    if (d == 3) din3 = w[6:0];
    else        din[d] = w;
    vin[d] = v;
  endtask

  // Push one word into an idle DUT and check every bit period's first and last cycle
  task automatic check_frame(input int d, input logic [7:0] w, input logic [15:0] bits,
                             input int nbits);
    set_in(d, w, 1'b1);
    step();
    set_in(d, w, 1'b0);
    chk("push_count", 32'(cnt[d]), 32'd1);
    chk("push_busy", 32'(bsy[d]), 32'd1);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 10; c++) begin
        step();
        if (c == 0 || c == 9) chk($sformatf("dut%0d_bit%0d_c%0d", d, b, c), 32'(txo[d]), 32'(bits[b]));
        if (c == 0) chk("busy_in_frame", 32'(bsy[d]), 32'd1);
      end
    end
    step();
    chk("busy_fall", 32'(bsy[d]), 32'd0);
    chk("tx_idle", 32'(txo[d]), 32'd1);
    chk("count_empty", 32'(cnt[d]), 32'd0);
  endtask

  // Decode n back-to-back 8N1 frames on dut0; the current cycle is the first start cycle
  task automatic check_stream(input logic [7:0] w [6], input int n);
    logic [9:0] fr;
    for (int f = 0; f < n; f++) begin
      fr = {1'b1, w[f], 1'b0};
      for (int c = 0; c < 100; c++) begin
        if (!(f == 0 && c == 0)) step();
        if (c == 0) chk($sformatf("stream%0d_start_edge", f), 32'(txo[0]), 32'd0);
        if (c % 10 == 5) chk($sformatf("stream%0d_bit%0d", f, c / 10), 32'(txo[0]), 32'(fr[c / 10]));
      end
    end
    chk("stream_busy_last", 32'(bsy[0]), 32'd1);
    step();
    chk("stream_busy_fall", 32'(bsy[0]), 32'd0);
    chk("stream_tx_idle", 32'(txo[0]), 32'd1);
  endtask

  initial begin
    logic [7:0] ws [6];
    int idx, guard, peak, r, saw_low, started;

    vecs[0] = '{dut: 0, word: 8'hAC, bits: 16'h0358, nbits: 10};
    vecs[1] = '{dut: 0, word: 8'h00, bits: 16'h0200, nbits: 10};
    vecs[2] = '{dut: 1, word: 8'h07, bits: 16'h060E, nbits: 11};
    vecs[3] = '{dut: 1, word: 8'hFF, bits: 16'h05FE, nbits: 11};
    vecs[4] = '{dut: 2, word: 8'h07, bits: 16'h040E, nbits: 11};
    vecs[5] = '{dut: 2, word: 8'hFF, bits: 16'h07FE, nbits: 11};
    vecs[6] = '{dut: 3, word: 8'h55, bits: 16'h03AA, nbits: 10};
    vecs[7] = '{dut: 3, word: 8'h3F, bits: 16'h037E, nbits: 10};

    for (int d = 0; d < 4; d++) set_in(d, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_tx%0d", d), 32'(txo[d]), 32'd1);
      chk($sformatf("rst_busy%0d", d), 32'(bsy[d]), 32'd0);
      chk($sformatf("rst_count%0d", d), 32'(cnt[d]), 32'd0);
      chk($sformatf("rst_ready%0d", d), 32'(rdy[d]), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single frames across all parameter sets
    for (int i = 0; i < 8; i++) begin
      check_frame(vecs[i].dut, vecs[i].word, vecs[i].bits, vecs[i].nbits);
      repeat (2) step();
    end

    // FIFO fill: six words held on valid while idle, depth 4
    for (int i = 0; i < 6; i++) ws[i] = 8'(i + 1);
    idx = 0; guard = 0; peak = 0; saw_low = 0; started = 0;
    set_in(0, 8'h01, 1'b1);
    fork
      begin
        while (idx < 6 && guard < 400) begin
          r = rdy[0];
          step();
          guard++;
          if (int'(cnt[0]) > peak) peak = int'(cnt[0]);
          if (!rdy[0]) saw_low = 1;
          if (r != 0) begin
            idx++;
            if (idx < 6) set_in(0, ws[idx], 1'b1);
            else         set_in(0, 8'h00, 1'b0);
          end
        end
        set_in(0, 8'h00, 1'b0);
        chk("fill_all_pushed", 32'(idx), 32'd6);
      end
      begin
        for (int t = 0; t < 20 && started == 0; t++) begin
          step();
          if (txo[0] == 1'b0) started = 1;
        end
        chk("fill_first_start", 32'(started), 32'd1);
        if (started != 0) check_stream(ws, 6);
      end
    join
    chk("fill_peak_count", 32'(peak), 32'd4);
    chk("fill_ready_dropped", 32'(saw_low), 32'd1);
    repeat (2) step();

    // Push coinciding with the end-of-stop pop while two words are queued
    ws[0] = 8'h3C; ws[1] = 8'hC3; ws[2] = 8'h5A; ws[3] = 8'h96;
    set_in(0, ws[0], 1'b1);
    step();                                 // A accepted
    set_in(0, ws[1], 1'b1);
    step();                                 // A popped, B accepted
    set_in(0, ws[2], 1'b1);
    step();                                 // C accepted
    set_in(0, 8'h00, 1'b0);
    chk("pp_count_before", 32'(cnt[0]), 32'd2);
    repeat (98) step();                     // last cycle of A's stop bit
    chk("pp_stop_level", 32'(txo[0]), 32'd1);
    chk("pp_count_pre", 32'(cnt[0]), 32'd2);
    set_in(0, ws[3], 1'b1);
    step();                                 // B popped, D pushed on the same edge
    set_in(0, 8'h00, 1'b0);
    chk("pp_count_same", 32'(cnt[0]), 32'd2);
    ws[0] = ws[1]; ws[1] = ws[2]; ws[2] = ws[3];
    check_stream(ws, 3);
    repeat (2) step();

    // Reset during data bit 3 with words still queued
    set_in(0, 8'hA4, 1'b1);
    step();
    set_in(0, 8'h11, 1'b1);
    step();
    set_in(0, 8'h22, 1'b1);
    step();
    set_in(0, 8'h00, 1'b0);
    repeat (43) step();                     // mid data bit 3 of 0xA4, which is 0
    chk("mid_bit3_low", 32'(txo[0]), 32'd0);
    chk("mid_count", 32'(cnt[0]), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx", 32'(txo[0]), 32'd1);
    chk("arst_count", 32'(cnt[0]), 32'd0);
    chk("arst_ready", 32'(rdy[0]), 32'd1);
    chk("arst_busy", 32'(bsy[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    check_frame(0, 8'hAC, 16'h0358, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
